// File: rtl/scdp_sequencer.sv
// ---------------------------------------------------------------------------
// scdp_sequencer -- control sequencer for a single-cycle-datapath style core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> WB (BEQ retires
// from EXEC and skips WB). HALT parks the sequencer in DONE. Retirement stops
// once instr_count reaches MAX_INSTR. All outputs are Moore, decoded from the
// current state plus the opcode latched in DECODE.
//
// Optional feature macro: SCDP_SEQ_SINGLE_STEP_EN
//   When defined, adds input step_i and a PAUSE state entered after every
//   retirement; step_i=1 in PAUSE moves on to the next FETCH.
//
// Ports:
//   clk_i          single clock, rising edge
//   reset_i        synchronous active-high reset
//   start_i        launch request (honoured in IDLE and DONE only)
//   start_pc_i     first instruction address
//   opcode_i       opcode of the instruction at pc_o
//   imm_i          two's-complement branch offset
//   alu_zero_i     datapath ALU zero flag
//   step_i         single-step advance (SCDP_SEQ_SINGLE_STEP_EN only)
//   pc_o           current instruction address
//   ir_we_o        instruction-register load strobe
//   reg_we_o       register-file write enable
//   mem_we_o       data-memory write enable
//   alu_src_o      ALU operand B: 0 register, 1 immediate
//   alu_op_o       00 add, 01 sub, 10 funct-decoded
//   busy_o         instruction in flight
//   done_o         sequencer in DONE
//   instr_count_o  instructions retired since last launch
// ---------------------------------------------------------------------------
module scdp_sequencer #(
    parameter logic [7:0] MAX_INSTR = 8'd200
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [4:0] start_pc_i,
    input  logic [5:0] opcode_i,
    input  logic [4:0] imm_i,
    input  logic       alu_zero_i,
`ifdef SCDP_SEQ_SINGLE_STEP_EN
    input  logic       step_i,
`endif
    output logic [4:0] pc_o,
    output logic       ir_we_o,
    output logic       reg_we_o,
    output logic       mem_we_o,
    output logic       alu_src_o,
    output logic [1:0] alu_op_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] instr_count_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

`ifdef SCDP_SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE, S_PAUSE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;

    logic [4:0] pc_inc;
    logic [4:0] pc_br;
    logic [7:0] cnt_inc;
    logic       at_limit;
    state_t     retire_next;

    // 5-bit adds wrap modulo 32; adding the raw 5-bit imm is the same as
    // adding its sign extension and truncating.
    assign pc_inc   = pc_q + 5'd1;
    assign pc_br    = pc_inc + imm_i;
    // Saturate at 8'hFF so the counter can never wrap, even for odd limits.
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign at_limit = (cnt_inc == MAX_INSTR) || (cnt_q == 8'hFF);

    // Where a retiring instruction goes; the limit wins over single-step.
`ifdef SCDP_SEQ_SINGLE_STEP_EN
    assign retire_next = at_limit ? S_DONE : S_PAUSE;
`else
    assign retire_next = at_limit ? S_DONE : S_FETCH;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= 5'd0;
            cnt_q   <= 8'd0;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        ir_we_o   = 1'b0;
        reg_we_o  = 1'b0;
        mem_we_o  = 1'b0;
        alu_src_o = 1'b0;
        alu_op_o  = 2'b00;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done_o = (state_q == S_DONE);
                if (start_i) begin
                    pc_d    = start_pc_i;
                    cnt_d   = 8'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                busy_o  = 1'b1;
                ir_we_o = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                busy_o  = 1'b1;
                op_d    = opcode_i;
                // HALT does not retire, so the count is left alone.
                state_d = (opcode_i == OP_HALT) ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                busy_o = 1'b1;
                case (op_q)
                    OP_RTYPE:     alu_op_o  = 2'b10;
                    OP_LW, OP_SW: alu_src_o = 1'b1;
                    OP_BEQ:       alu_op_o  = 2'b01;
                    default:      ;
                endcase
                if (op_q == OP_BEQ) begin
                    pc_d    = alu_zero_i ? pc_br : pc_inc;
                    cnt_d   = cnt_inc;
                    state_d = retire_next;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                busy_o   = 1'b1;
                reg_we_o = (op_q == OP_RTYPE) || (op_q == OP_LW);
                mem_we_o = (op_q == OP_SW);
                pc_d     = pc_inc;
                cnt_d    = cnt_inc;
                state_d  = retire_next;
            end
`ifdef SCDP_SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                busy_o = 1'b1;
                if (step_i) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign pc_o          = pc_q;
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_scdp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scdp_sequencer -- directed self-checking bench for scdp_sequencer.
// A second instance with MAX_INSTR=3 exercises the retirement limit.
// ---------------------------------------------------------------------------
module tb_scdp_sequencer;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic       clk = 1'b0;
    logic       reset, start, start3, alu_zero;
    logic [4:0] start_pc, imm;
    logic [5:0] opcode;

    logic [4:0] pc, pc3;
    logic       ir_we, reg_we, mem_we, alu_src, busy, done;
    logic       ir_we3, reg_we3, mem_we3, alu_src3, busy3, done3;
    logic [1:0] alu_op, alu_op3;
    logic [7:0] cnt, cnt3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scdp_sequencer dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .start_pc_i(start_pc),
        .opcode_i(opcode), .imm_i(imm), .alu_zero_i(alu_zero),
        .pc_o(pc), .ir_we_o(ir_we), .reg_we_o(reg_we), .mem_we_o(mem_we),
        .alu_src_o(alu_src), .alu_op_o(alu_op), .busy_o(busy), .done_o(done),
        .instr_count_o(cnt)
    );

    scdp_sequencer #(.MAX_INSTR(8'd3)) dut3 (
        .clk_i(clk), .reset_i(reset), .start_i(start3), .start_pc_i(start_pc),
        .opcode_i(opcode), .imm_i(imm), .alu_zero_i(alu_zero),
        .pc_o(pc3), .ir_we_o(ir_we3), .reg_we_o(reg_we3), .mem_we_o(mem_we3),
        .alu_src_o(alu_src3), .alu_op_o(alu_op3), .busy_o(busy3), .done_o(done3),
        .instr_count_o(cnt3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; checks and new inputs happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".pc"}, pc, 0);
        check({tag, ".cnt"}, cnt, 0);
        check({tag, ".we"}, {ir_we, reg_we, mem_we}, 0);
        check({tag, ".alu"}, {alu_op, alu_src}, 0);
        check({tag, ".busy_done"}, {busy, done}, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start3 = 1'b0; alu_zero = 1'b0;
        start_pc = 5'd0; imm = 5'd0; opcode = OP_R;
        tick(); tick();
        check_idle("reset");
        check("reset.dut3", {busy3, done3, cnt3}, 0);

        // R-type from pc 5: ir_we @1, reg_we @4, pc=6/cnt=1 @5
        reset = 1'b0; start = 1'b1; start_pc = 5'd5; opcode = OP_R;
        tick(); start = 1'b0;
        check("r.fetch", {ir_we, reg_we, mem_we, busy}, 4'b1001);
        tick();
        check("r.decode", {ir_we, reg_we, mem_we}, 0);
        tick();
        check("r.exec_alu", {alu_op, alu_src}, 3'b100);
        tick();
        check("r.wb", {ir_we, reg_we, mem_we}, 3'b010);
        tick();
        check("r.next_pc", pc, 6);
        check("r.next_cnt", cnt, 1);
        check("r.next_we", {ir_we, reg_we, mem_we}, 3'b100);

        // BEQ pc6 taken imm=-2 -> 5; pc5 taken imm=-2 -> 4; pc4 imm=+1 -> 6;
        // pc6 not taken -> 7. Each 3 cycles, no register/memory writes.
        opcode = OP_BEQ; alu_zero = 1'b1; imm = 5'b11110;
        tick(); check("beq1.dec_we", {reg_we, mem_we}, 0);
        tick(); check("beq1.exec", {alu_op, alu_src, reg_we, mem_we}, 5'b01000);
        tick(); check("beq1.pc", pc, 5); check("beq1.cnt", cnt, 2);
        tick(); tick(); check("beq2.exec_we", {reg_we, mem_we}, 0);
        tick(); check("beq2.pc", pc, 4); check("beq2.fetch", ir_we, 1);
        imm = 5'b00001;
        tick(); tick(); tick(); check("beq3.pc", pc, 6);
        alu_zero = 1'b0; imm = 5'b00111;
        tick(); tick(); tick(); check("beq4.pc", pc, 7); check("beq4.cnt", cnt, 5);

        // SW at pc 31: mem_we in WB only, pc wraps to 0
        reset = 1'b1; tick(); check_idle("rst2");
        reset = 1'b0; start = 1'b1; start_pc = 5'd31; opcode = OP_SW;
        tick(); start = 1'b0;
        tick();
        tick(); check("sw.exec", {alu_op, alu_src, mem_we}, 4'b0010);
        tick(); check("sw.wb", {ir_we, reg_we, mem_we}, 3'b001);
        tick(); check("sw.pc_wrap", pc, 0); check("sw.mem_off", mem_we, 0);
        check("sw.cnt", cnt, 1);

        // HALT at pc 9 after one retired R-type
        reset = 1'b1; tick();
        reset = 1'b0; start = 1'b1; start_pc = 5'd8; opcode = OP_R;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        check("halt.pre_pc", pc, 9);
        opcode = OP_HALT;
        tick(); check("halt.decode", {busy, done}, 2'b10);
        tick(); check("halt.done", {busy, done}, 2'b01);
        check("halt.pc", pc, 9); check("halt.cnt", cnt, 1);
        tick(); check("halt.hold", {done, pc, cnt}, {1'b1, 5'd9, 8'd1});

        // Relaunch from DONE, then LW; start while busy is ignored
        start = 1'b1; start_pc = 5'd3; opcode = OP_LW;
        tick();
        check("relaunch", {busy, done, pc, cnt}, {2'b10, 5'd3, 8'd0});
        start_pc = 5'd20;      // start still high: must be ignored now
        tick(); start = 1'b0;
        check("busy_start.pc", pc, 3);
        tick(); check("lw.exec", {alu_op, alu_src}, 3'b001);
        tick(); check("lw.wb", {reg_we, mem_we}, 2'b10);
        // Reset during WB, with start high in the same cycle
        reset = 1'b1; start = 1'b1;
        tick(); check_idle("rst_wb");
        reset = 1'b0; start = 1'b0;
        tick(); check_idle("rst_wb.after");

        // MAX_INSTR=3: R-type stream stops right after the third WB
        start3 = 1'b1; start_pc = 5'd0; opcode = OP_R;
        tick(); start3 = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("max.wb3", {reg_we3, cnt3}, {1'b1, 8'd2});
        tick();
        check("max.done", {done3, busy3, ir_we3}, 3'b100);
        check("max.cnt", cnt3, 3); check("max.pc", pc3, 3);
        tick();
        check("max.hold", {done3, cnt3}, {1'b1, 8'd3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scdp_sequencer.md
SCDP_SEQUENCER -- requirements
Module: scdp_sequencer

Interface
REQ-001 Parameter MAX_INSTR, default 8'd200: retired-instruction limit; reaching it forces DONE.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  launch request; sampled only in IDLE or DONE.
REQ-005 start_pc  input  5  first instruction address.
REQ-006 opcode  input  6  opcode of instruction at pc, from instruction memory.
REQ-007 imm  input  5  branch offset, two's complement.
REQ-008 alu_zero  input  1  datapath ALU zero flag.
REQ-009 pc  output  5  current instruction address to datapath.
REQ-010 ir_we  output  1  instruction-register load strobe.
REQ-011 reg_we  output  1  register-file write enable.
REQ-012 mem_we  output  1  data-memory write enable.
REQ-013 alu_src  output  1  ALU operand B select: 0 = register, 1 = immediate.
REQ-014 alu_op  output  2  00 add, 01 sub, 10 funct-decoded, 11 unused.
REQ-015 busy  output  1  high in FETCH, DECODE, EXEC, WB (and PAUSE when compiled in).
REQ-016 done  output  1  high in DONE.
REQ-017 instr_count  output  8  instructions retired since last launch.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, WB, DONE; all outputs SHALL be Moore, decoded from state plus the opcode latched in DECODE.
REQ-019 Opcodes: 000000 R-type, 100011 LW, 101011 SW, 000100 BEQ, 111111 HALT; any other opcode SHALL execute as NOP (no enables asserted, pc+1).
REQ-020 IDLE: start=1 -> pc<=start_pc, instr_count<=0, go to FETCH.
REQ-021 FETCH: ir_we=1 for exactly one cycle -> DECODE.
REQ-022 DECODE: latch opcode; HALT -> DONE without incrementing instr_count; otherwise -> EXEC.
REQ-023 EXEC alu_op/alu_src: R-type 10/0, LW 00/1, SW 00/1, BEQ 01/0, NOP 00/0.
REQ-024 EXEC, BEQ: pc <= alu_zero ? pc+1+imm : pc+1 (imm sign-extended, sum modulo 32); instr_count++; -> FETCH (BEQ skips WB).
REQ-025 EXEC, other opcodes: -> WB.
REQ-026 WB: reg_we=1 for R-type/LW, mem_we=1 for SW, one cycle only; pc<=pc+1 modulo 32 (31 wraps to 0); instr_count++; -> FETCH.
REQ-027 Cycles per instruction: BEQ 3, all others 4; HALT reaches DONE 2 cycles after its FETCH.
REQ-028 When an increment makes instr_count equal MAX_INSTR, next state SHALL be DONE instead of FETCH; instr_count SHALL never wrap.
REQ-029 DONE: done=1; pc and instr_count hold; start=1 relaunches exactly as from IDLE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 reg_we, mem_we, ir_we SHALL never be asserted in the same cycle.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE, pc=0, instr_count=0, all enables=0, alu_op=00, alu_src=0, busy=0, done=0, from any state, including mid-instruction.
REQ-033 reset SHALL take priority over start in the same cycle.
REQ-034 A write enable active in the reset cycle SHALL be deasserted on the next edge; no further write occurs.

Configuration
REQ-035 Macro SCDP_SEQ_SINGLE_STEP_EN defined: adds input step (1 bit) and state PAUSE; every WB or BEQ EXEC that would go to FETCH SHALL go to PAUSE instead, and PAUSE -> FETCH on step=1; busy=1 in PAUSE; the MAX_INSTR check takes priority over PAUSE.
REQ-036 Macro undefined: no step port, no PAUSE state; behaviour exactly as REQ-018..REQ-031.

Verification
REQ-037 reset 2 cycles, start=1 with start_pc=5, opcode=000000 -> ir_we at cycle 1, reg_we at cycle 4, pc=6 and instr_count=1 at cycle 5.
REQ-038 pc=5, BEQ with imm=5'b11110, alu_zero=1 -> pc=4 after 3 cycles, no reg_we/mem_we pulse; with alu_zero=0 -> pc=6.
REQ-039 pc=31, SW -> mem_we one cycle in WB, pc wraps to 0.
REQ-040 HALT at pc=9 -> done=1 two cycles after its FETCH, pc holds 9, instr_count unchanged; start=1 relaunches.
REQ-041 MAX_INSTR=3, stream of R-type -> done=1 right after third WB, instr_count=3.
REQ-042 reset asserted during WB of LW -> next cycle IDLE, all outputs at reset values; start pulsed while busy -> no effect.
